// File: rtl/clk_div_gen.sv
//==============================================================================
// Module      : clk_div_gen
// Description : NUM_CH independent programmable dividers producing a one-cycle
//               tick enable and a near-50% level per channel. Optional per-
//               channel tick counters are built when CLK_DIV_TICK_CNT_EN is set.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_div_gen #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] divisor,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       pend,
    output logic [NUM_CH*16-1:0]    tick_cnt
);

    localparam int c_TCW = 16;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_pdiv;
        logic [WIDTH-1:0] r_cnt;
        logic             r_pend;
        logic             r_tick;
        logic             r_clk;

        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] w_dnext;
        logic [WIDTH-1:0] w_cnext;
        logic [WIDTH-1:0] w_half;
        logic             w_run;
        logic             w_wrap;
        logic             w_apply;
        logic             w_live;

        assign w_din  = divisor[i*WIDTH +: WIDTH];
        assign w_run  = enable[i] && (r_div != '0);
        assign w_wrap = w_run && (r_cnt == (r_div - WIDTH'(1)));

        // A load landing on the wrap edge bypasses the pending register.
        assign w_apply = w_wrap ? (load[i] || r_pend) : (!w_run && r_pend);
        assign w_dnext = !w_apply            ? r_div :
                         (w_wrap && load[i]) ? w_din : r_pdiv;

        assign w_cnext = (!w_run || w_wrap) ? '0 : r_cnt + WIDTH'(1);
        assign w_half  = (w_dnext >> 1) + {{(WIDTH-1){1'b0}}, w_dnext[0]};
        assign w_live  = w_run && (w_dnext != '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_div  <= '0;
                r_pdiv <= '0;
                r_cnt  <= '0;
                r_pend <= 1'b0;
                r_tick <= 1'b0;
                r_clk  <= 1'b0;
            end else begin
                r_div <= w_dnext;
                if (load[i]) begin
                    r_pdiv <= w_din;
                end
                if (w_wrap) begin
                    r_pend <= 1'b0;
                end else if (w_apply) begin
                    r_pend <= load[i];
                end else begin
                    r_pend <= r_pend | load[i];
                end
                r_cnt  <= w_cnext;
                r_tick <= w_wrap && w_live;
                r_clk  <= w_live && (w_cnext < w_half);
            end
        end

        assign tick[i]    = r_tick;
        assign clk_out[i] = r_clk;
        assign pend[i]    = r_pend;

`ifdef CLK_DIV_TICK_CNT_EN
        logic [c_TCW-1:0] r_tc;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_tc <= '0;
            end else if (w_apply) begin
                r_tc <= '0;
            end else if (r_tick) begin
                r_tc <= r_tc + c_TCW'(1);
            end
        end

        assign tick_cnt[i*c_TCW +: c_TCW] = r_tc;
`else
        assign tick_cnt[i*c_TCW +: c_TCW] = '0;
`endif
    end : g_ch

endmodule : clk_div_gen

`default_nettype wire

// File: tb/tb_clk_div_gen.sv
// Testbench for clk_div_gen: cycle-level reference model feeding a scoreboard
// queue, plus directed checks of period, duty, latency and tick counting.
`default_nettype none

module tb_clk_div_gen;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_CH-1:0]       enable = '0;
    logic [NUM_CH-1:0]       load = '0;
    logic [NUM_CH*WIDTH-1:0] divisor = '0;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       pend;
    logic [NUM_CH*16-1:0]    tick_cnt;

    clk_div_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (load),
        .divisor  (divisor),
        .tick     (tick),
        .clk_out  (clk_out),
        .pend     (pend),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0]    tick;
        logic [NUM_CH-1:0]    clk_out;
        logic [NUM_CH-1:0]    pend;
        logic [NUM_CH*16-1:0] tc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int unsigned m_d[NUM_CH], m_p[NUM_CH], m_cnt[NUM_CH], m_tc[NUM_CH];
    bit          m_pend[NUM_CH], m_tick[NUM_CH], m_clk[NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_d[c] = 0; m_p[c] = 0; m_cnt[c] = 0; m_tc[c] = 0;
            m_pend[c] = 1'b0; m_tick[c] = 1'b0; m_clk[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            bit          en, ld, run, wrap, applied, live;
            int unsigned nd, dn;
            en      = enable[c];
            ld      = load[c];
            nd      = int'(divisor[c*WIDTH +: WIDTH]);
            run     = en && (m_d[c] != 0);
            wrap    = run && (m_cnt[c] == m_d[c] - 1);
            dn      = m_d[c];
            applied = 1'b0;
            if (wrap) begin
                if (ld) begin
                    dn = nd; applied = 1'b1;
                end else if (m_pend[c]) begin
                    dn = m_p[c]; applied = 1'b1;
                end
                m_pend[c] = 1'b0;
            end else if (!run) begin
                if (m_pend[c]) begin
                    dn = m_p[c]; applied = 1'b1;
                end
                m_pend[c] = ld;
            end else if (ld) begin
                m_pend[c] = 1'b1;
            end
            if (ld) m_p[c] = nd;
`ifdef CLK_DIV_TICK_CNT_EN
            if (applied)        m_tc[c] = 0;
            else if (m_tick[c]) m_tc[c] = (m_tc[c] + 1) & 32'hFFFF;
`endif
            m_cnt[c]  = (!run || wrap) ? 0 : m_cnt[c] + 1;
            live      = run && (dn != 0);
            m_tick[c] = wrap && live;
            m_clk[c]  = live && (m_cnt[c] < (dn + 1) / 2);
            m_d[c]    = dn;
        end
    endtask

    // One clock: model the edge, queue the expectation, compare just after it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            e.tick[c]          = m_tick[c];
            e.clk_out[c]       = m_clk[c];
            e.pend[c]          = m_pend[c];
            e.tc[c*16 +: 16]   = m_tc[c][15:0];
        end
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check("tick", 32'(tick), 32'(e.tick));
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
        check("pend", 32'(pend), 32'(e.pend));
        for (int c = 0; c < NUM_CH; c++)
            check("tick_cnt", 32'(tick_cnt[c*16 +: 16]), 32'(e.tc[c*16 +: 16]));
    endtask

    task automatic set_div(input int c, input logic [WIDTH-1:0] v);
        divisor[c*WIDTH +: WIDTH] = v;
    endtask

    task automatic wait_tick(input int c, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[c] && n < max);
        check("tick timeout", 32'(tick[c]), 32'd1);
    endtask

    task automatic wait_pend_clear(input int c);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (pend[c] && n < 40);
        check("pend timeout", 32'(pend[c]), 32'd0);
    endtask

    initial begin
        int          n, pc, hi;
        int          tk[$];
        bit          clkh[64];
        logic [15:0] t0, dtc;

        model_reset();
        step();
        step();
        check("reset tick", 32'(tick), 32'd0);
        check("reset clk_out", 32'(clk_out), 32'd0);
        check("reset pend", 32'(pend), 32'd0);
        check("reset tick_cnt", 32'(tick_cnt[31:0] | tick_cnt[63:32]), 32'd0);
        reset_n = 1'b1;
        step();

        // ch0: divide by 5
        enable[0] = 1'b1; load[0] = 1'b1; set_div(0, 16'd5);
        step();
        load[0] = 1'b0;
        pc = int'(pend[0]);
        for (int k = 1; k <= 20; k++) begin
            step();
            pc += int'(pend[0]);
            clkh[k] = clk_out[0];
            if (tick[0]) tk.push_back(k);
        end
        check("ch0 pend width", pc, 1);
        check("ch0 tick count", tk.size(), 3);
        if (tk.size() >= 3) begin
            check("ch0 period a", tk[1] - tk[0], 5);
            check("ch0 period b", tk[2] - tk[1], 5);
            hi = 0;
            for (int k = 0; k < 5; k++) hi += int'(clkh[tk[0] + k]);
            check("ch0 high time", hi, 3);
            check("ch0 clk_out at tick", 32'(clkh[tk[0]]), 32'd1);
        end

        // ch1: divide by 4, then reload 7 mid-period
        enable[1] = 1'b1; load[1] = 1'b1; set_div(1, 16'd4);
        step();
        load[1] = 1'b0;
        wait_tick(1, 20, n);
        step();
        load[1] = 1'b1; set_div(1, 16'd7);
        step();
        load[1] = 1'b0;
        check("ch1 pend after load", 32'(pend[1]), 32'd1);
        wait_tick(1, 20, n);
        check("ch1 old period tail", n, 2);
        check("ch1 pend at apply", 32'(pend[1]), 32'd0);
        wait_tick(1, 20, n);
        check("ch1 new period a", n, 7);
        wait_tick(1, 20, n);
        check("ch1 new period b", n, 7);

        // ch1: drop enable mid-period, then re-enable
        step();
        check("ch1 clk_out high", 32'(clk_out[1]), 32'd1);
        enable[1] = 1'b0;
        step();
        check("ch1 off tick", 32'(tick[1]), 32'd0);
        check("ch1 off clk_out", 32'(clk_out[1]), 32'd0);
        repeat (3) step();
        enable[1] = 1'b1;
        wait_tick(1, 20, n);
        check("ch1 restart latency", n, 7);

        // ch2: divide by 1, then load 0
        enable[2] = 1'b1; load[2] = 1'b1; set_div(2, 16'd1);
        step();
        load[2] = 1'b0;
        step();
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            hi += int'(tick[2] & clk_out[2]);
        end
        check("ch2 div1 constant", hi, 5);
        load[2] = 1'b1; set_div(2, 16'd0);
        step();
        load[2] = 1'b0;
        check("ch2 stop tick", 32'(tick[2]), 32'd0);
        check("ch2 stop clk_out", 32'(clk_out[2]), 32'd0);
        check("ch2 stop pend", 32'(pend[2]), 32'd0);

        // ch0: divide by 2 for 200 cycles, then 3
        load[0] = 1'b1; set_div(0, 16'd2);
        step();
        load[0] = 1'b0;
        wait_pend_clear(0);
`ifdef CLK_DIV_TICK_CNT_EN
        check("tc clear at apply 2", 32'(tick_cnt[15:0]), 32'd0);
`endif
        repeat (3) step();
        t0 = tick_cnt[15:0];
        pc = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            pc += int'(tick[0]);
        end
        check("ch0 div2 ticks", pc, 100);
        dtc = tick_cnt[15:0] - t0;
`ifdef CLK_DIV_TICK_CNT_EN
        check("tc over 200 cycles", 32'(dtc), 32'd100);
`else
        check("tc tied off", 32'(dtc | tick_cnt[15:0]), 32'd0);
`endif
        load[0] = 1'b1; set_div(0, 16'd3);
        step();
        load[0] = 1'b0;
        wait_pend_clear(0);
`ifdef CLK_DIV_TICK_CNT_EN
        check("tc clear at apply 3", 32'(tick_cnt[15:0]), 32'd0);
`endif

        // ch0 divide by 1 (tick counter wrap) alongside ch3 maximum divisor
        load[0] = 1'b1; set_div(0, 16'd1);
        step();
        load[0] = 1'b0;
        wait_pend_clear(0);
        repeat (2) step();
        t0 = tick_cnt[15:0];
        load[3] = 1'b1; set_div(3, 16'hFFFF);
        step();
        load[3] = 1'b0;
        step();
        check("ch3 applied while disabled", 32'(pend[3]), 32'd0);
        t0 = tick_cnt[15:0] - 16'd2;
        enable[3] = 1'b1;
        wait_tick(3, 65600, n);
        check("ch3 first tick latency", n, 65535);
        step();
        dtc = tick_cnt[15:0] - t0;
`ifdef CLK_DIV_TICK_CNT_EN
        check("tc wrap after 65536 ticks", 32'(dtc), 32'd2);
`else
        check("tc tied off long run", 32'(dtc), 32'd2);
`endif
        check("ch0 div1 still ticking", 32'(tick[0]), 32'd1);

        // asynchronous reset between edges
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset tick", 32'(tick), 32'd0);
        check("async reset clk_out", 32'(clk_out), 32'd0);
        check("async reset pend", 32'(pend), 32'd0);
        check("async reset tick_cnt", 32'(tick_cnt[31:0] | tick_cnt[63:32]), 32'd0);
        step();
        reset_n = 1'b1;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(|tick);
        end
        check("divisors lost after reset", hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_gen

`default_nettype wire
